// File: rtl/game_pkg.sv
// Shared types and widths for the dinosaur-runner game-flow controller.
package game_pkg;

   localparam int unsigned SCORE_W = 16;
   localparam int unsigned LEVEL_W = 3;

   // Encoding is visible on the state output; 2'b11 is never entered.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StOver = 2'b10
   } state_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Button, datapath and control signals between the board/datapath side (master)
// and the game-flow controller (slave).
interface game_ctrl_if;
   import game_pkg::*;

   logic               btn_start;
   logic               btn_jump;
   logic               btn_player;
   logic               btn_hi;
   logic               isover;
   logic [SCORE_W-1:0] scr;
   logic               game_rst;
   logic               jump;
   logic               playernum;
   logic               showhighest;
   logic [LEVEL_W-1:0] spd_level;
   state_t             state;

   modport master (
      output btn_start, btn_jump, btn_player, btn_hi, isover, scr,
      input  game_rst, jump, playernum, showhighest, spd_level, state
   );

   modport slave (
      input  btn_start, btn_jump, btn_player, btn_hi, isover, scr,
      output game_rst, jump, playernum, showhighest, spd_level, state
   );

endinterface

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce and rising-edge pulse.
module btn_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic re_start,
   input  logic btn_i,
   output logic level,
   output logic pulse
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d, level_prev_q, pulse_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles the synchronized value disagrees with the accepted level;
   // any agreement (i.e. a change back) restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer, debounce state and registered edge detector.
   always_ff @(posedge clk or posedge re_start) begin
      if (re_start) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         pulse_q      <= 1'b0;
      end else begin
         sync1_q      <= btn_i;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         pulse_q      <= level_q & ~level_prev_q;
      end
   end

   assign level = level_q;
   assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: conditions the four buttons and sequences IDLE/RUN/OVER.
// Optional feature macro: GAME_CTRL_AUTOSPEED_EN (score-driven speed level in RUN).
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
   parameter int unsigned OVER_HOLD_CYCLES = 50_000_000,
   parameter int unsigned PTS_PER_LEVEL    = 8,
   parameter int unsigned MAX_LEVEL        = 6
) (
   input logic        clk,
   input logic        re_start,
   game_ctrl_if.slave gc_if
);

   localparam int unsigned HoldW = $clog2(OVER_HOLD_CYCLES + 1);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(OVER_HOLD_CYCLES);

   logic start_p, jump_p, player_p, hi_level;
   logic start_lvl, jump_lvl, player_lvl, hi_p;

   state_t           state_q, state_d;
   logic             game_rst_q, game_rst_d;
   logic             jump_q, jump_d;
   logic             player_q, player_d;
   logic             show_q, show_d;
   logic [HoldW-1:0] hold_q, hold_d;

   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
      .clk(clk), .re_start(re_start), .btn_i(gc_if.btn_start), .level(start_lvl), .pulse(start_p)
   );
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_jump (
      .clk(clk), .re_start(re_start), .btn_i(gc_if.btn_jump), .level(jump_lvl), .pulse(jump_p)
   );
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_player (
      .clk(clk), .re_start(re_start), .btn_i(gc_if.btn_player), .level(player_lvl),
      .pulse(player_p)
   );
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hi (
      .clk(clk), .re_start(re_start), .btn_i(gc_if.btn_hi), .level(hi_level), .pulse(hi_p)
   );

   // Phase sequencing, one-cycle pulses, player toggle and game-over hold timer.
   always_comb begin
      state_d    = state_q;
      game_rst_d = 1'b0;
      jump_d     = 1'b0;
      player_d   = player_q;
      hold_d     = hold_q;
      case (state_q)
         StIdle: begin
            if (player_p) player_d = ~player_q;
            if (start_p) begin
               game_rst_d = 1'b1;
               state_d    = StRun;
            end
         end
         StRun: begin
            // Collision outranks a jump request in the same cycle.
            if (gc_if.isover) begin
               state_d = StOver;
               hold_d  = '0;
            end else if (jump_p) begin
               jump_d = 1'b1;
            end
         end
         StOver: begin
            if (hold_q != HoldMax) hold_d = hold_q + 1'b1;
            if (player_p) player_d = ~player_q;
            if (start_p && (hold_q == HoldMax)) begin
               game_rst_d = 1'b1;
               state_d    = StRun;
            end
         end
         default: state_d = StIdle;
      endcase
      show_d = (state_d != StRun) & hi_level;
   end

   // Controller state register.
   always_ff @(posedge clk or posedge re_start) begin
      if (re_start) begin
         state_q    <= StIdle;
         game_rst_q <= 1'b0;
         jump_q     <= 1'b0;
         player_q   <= 1'b0;
         show_q     <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         game_rst_q <= game_rst_d;
         jump_q     <= jump_d;
         player_q   <= player_d;
         show_q     <= show_d;
         hold_q     <= hold_d;
      end
   end

`ifdef GAME_CTRL_AUTOSPEED_EN
   localparam int unsigned LvlShift = $clog2(PTS_PER_LEVEL);

   logic [SCORE_W-1:0] lvl_raw;
   logic [LEVEL_W-1:0] spd_q, spd_d;

   assign lvl_raw = gc_if.scr >> LvlShift;

   // Speed level follows the score while running, restarts at 0 with each new game.
   always_comb begin
      spd_d = spd_q;
      if (game_rst_d) begin
         spd_d = '0;
      end else if (state_q == StRun) begin
         spd_d = (lvl_raw > SCORE_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : lvl_raw[LEVEL_W-1:0];
      end
   end

   // Speed level register.
   always_ff @(posedge clk or posedge re_start) begin
      if (re_start) spd_q <= '0;
      else          spd_q <= spd_d;
   end

   assign gc_if.spd_level = spd_q;
`else
   assign gc_if.spd_level = '0;
`endif

   assign gc_if.state       = state_q;
   assign gc_if.game_rst    = game_rst_q;
   assign gc_if.jump        = jump_q;
   assign gc_if.playernum   = player_q;
   assign gc_if.showhighest = show_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized buttons,
// collisions and scores, all checked against a cycle-level behavioural model.
module tb_game_ctrl;
   import game_pkg::*;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 16;
   localparam int unsigned PTS  = 8;
   localparam int unsigned MAXL = 6;
   localparam int BS = 0, BJ = 1, BP = 2, BH = 3;

   logic       clk = 1'b0;
   logic       re_start;
   logic [3:0] btn;

   game_ctrl_if gc_if ();

   assign gc_if.btn_start  = btn[BS];
   assign gc_if.btn_jump   = btn[BJ];
   assign gc_if.btn_player = btn[BP];
   assign gc_if.btn_hi     = btn[BH];

   game_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .OVER_HOLD_CYCLES(HOLD),
      .PTS_PER_LEVEL   (PTS),
      .MAX_LEVEL       (MAXL)
   ) dut (
      .clk     (clk),
      .re_start(re_start),
      .gc_if   (gc_if)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state: raw samples per button (index 0 = newest), accepted levels,
   // pulses and the expected outputs.
   bit smp [4][0:DEB+1];
   bit m_lev [4];
   bit m_lev_old [4];
   bit m_pulse [4];
   int e_state, e_hold, e_spd;
   bit e_rst, e_jump, e_player, e_show;

   int cyc = 0;
   int cnt_rst = 0;
   int cnt_jmp = 0;
   int first_rst = -1;

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i <= DEB + 1; i++) smp[b][i] = 1'b0;
         m_lev[b] = 1'b0; m_lev_old[b] = 1'b0; m_pulse[b] = 1'b0;
      end
      e_state = 0; e_hold = 0; e_spd = 0;
      e_rst = 0; e_jump = 0; e_player = 0; e_show = 0;
   endtask

   task automatic model_step();
      bit pre_p [4];
      bit pre_hi, np, stable, start_ok;
      int ns;
      for (int b = 0; b < 4; b++) pre_p[b] = m_pulse[b];
      pre_hi = m_lev[BH];
      // A button level is accepted once the synchronized input (raw delayed by 2)
      // has shown the same value for DEB consecutive cycles.
      for (int b = 0; b < 4; b++) begin
         np = m_lev[b] & ~m_lev_old[b];
         for (int i = DEB + 1; i > 0; i--) smp[b][i] = smp[b][i-1];
         smp[b][0] = btn[b];
         stable = 1'b1;
         for (int i = 3; i <= DEB + 1; i++) if (smp[b][i] != smp[b][2]) stable = 1'b0;
         m_lev_old[b] = m_lev[b];
         if (stable) m_lev[b] = smp[b][2];
         m_pulse[b] = np;
      end
      ns = e_state; e_rst = 0; e_jump = 0; start_ok = 0;
      if (e_state == 0 || e_state == 2) begin
         if (pre_p[BP]) e_player = ~e_player;
         start_ok = pre_p[BS] && (e_state == 0 || e_hold >= HOLD);
         if (start_ok) begin e_rst = 1; ns = 1; end
         if (e_state == 2 && e_hold < HOLD) e_hold++;
      end else if (e_state == 1) begin
         if (gc_if.isover) begin ns = 2; e_hold = 0; end
         else if (pre_p[BJ]) e_jump = 1;
      end
`ifdef GAME_CTRL_AUTOSPEED_EN
      if (start_ok) e_spd = 0;
      else if (e_state == 1) e_spd = (gc_if.scr / PTS > MAXL) ? MAXL : gc_if.scr / PTS;
`endif
      e_state = ns;
      e_show  = (ns != 1) && pre_hi;
   endtask

   task automatic check_outputs();
      check_val("state", gc_if.state, e_state);
      check_val("game_rst", gc_if.game_rst, e_rst);
      check_val("jump", gc_if.jump, e_jump);
      check_val("playernum", gc_if.playernum, e_player);
      check_val("showhighest", gc_if.showhighest, e_show);
      check_val("spd_level", gc_if.spd_level, e_spd);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check_outputs();
      if (gc_if.game_rst === 1'b1) begin
         cnt_rst++;
         if (first_rst < 0) first_rst = cyc;
      end
      if (gc_if.jump === 1'b1) cnt_jmp++;
   endtask

   task automatic press(input int b, input int n);
      btn[b] = 1'b1;
      repeat (n) tick();
      btn[b] = 1'b0;
   endtask

   task automatic apply_reset();
      re_start = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_state", gc_if.state, 0);
      check_val("rst_outs", {gc_if.game_rst, gc_if.jump, gc_if.playernum, gc_if.showhighest,
                             gc_if.spd_level}, 0);
      re_start = 1'b0;
   endtask

   int c0, t0, seen;
   int unsigned sc_tab [5] = '{0, 7, 8, 23, 60};
   int unsigned lv_tab [5] = '{0, 0, 1, 2, 6};

   initial begin
      btn = '0;
      gc_if.isover = 1'b0;
      gc_if.scr = '0;
      apply_reset();

      // Two-cycle glitch is rejected.
      c0 = cnt_rst;
      press(BS, 2);
      repeat (12) tick();
      check_val("glitch_no_rst", cnt_rst - c0, 0);
      check_val("glitch_idle", gc_if.state, 0);

      // Genuine press: one restart pulse, 8 cycles after the press.
      c0 = cnt_rst; t0 = cyc; first_rst = -1;
      press(BS, 10);
      repeat (6) tick();
      check_val("start_rst_count", cnt_rst - c0, 1);
      check_val("start_rst_lat", first_rst - t0, 8);
      check_val("start_run", gc_if.state, 1);

      // Player select is ignored while running.
      press(BP, 10);
      repeat (6) tick();
      check_val("player_in_run", gc_if.playernum, 0);

      // Plain jump.
      c0 = cnt_jmp;
      press(BJ, 10);
      repeat (6) tick();
      check_val("jump_count", cnt_jmp - c0, 1);

      // Jump pulse coincides with collision; a start press lands at hold count 5.
      c0 = cnt_jmp; t0 = cnt_rst;
      btn[BJ] = 1'b1;
      repeat (6) tick();
      btn[BS] = 1'b1;
      tick();
      gc_if.isover = 1'b1;
      tick();
      check_val("collide_over", gc_if.state, 2);
      check_val("collide_no_jump", gc_if.jump, 0);
      gc_if.isover = 1'b0;
      repeat (8) tick();
      btn[BS] = 1'b0; btn[BJ] = 1'b0;
      repeat (4) tick();
      check_val("hold_ignore_state", gc_if.state, 2);
      check_val("hold_ignore_rst", cnt_rst - t0, 0);
      check_val("collide_jump_count", cnt_jmp - c0, 0);

      // Player toggles in OVER, then a late start restarts.
      press(BP, 10);
      repeat (6) tick();
      check_val("player_in_over", gc_if.playernum, 1);
      c0 = cnt_rst;
      press(BS, 10);
      repeat (6) tick();
      check_val("restart_rst", cnt_rst - c0, 1);
      check_val("restart_run", gc_if.state, 1);

      // Speed level tracks the score one cycle later.
      for (int i = 0; i < 5; i++) begin
         gc_if.scr = 16'(sc_tab[i]);
         tick();
`ifdef GAME_CTRL_AUTOSPEED_EN
         check_val("spd_table", gc_if.spd_level, lv_tab[i]);
`else
         check_val("spd_table", gc_if.spd_level, 0);
`endif
      end
      gc_if.isover = 1'b1;
      tick();
      gc_if.isover = 1'b0;
      repeat (20) tick();
      press(BS, 10);
      repeat (6) tick();
      check_val("spd_after_restart", gc_if.spd_level, 0);

      // Start and player together from IDLE.
      c0 = cnt_rst;
      apply_reset();
      check_val("reset_no_rst", cnt_rst - c0, 0);
      btn[BS] = 1'b1; btn[BP] = 1'b1;
      repeat (10) tick();
      btn = '0;
      repeat (6) tick();
      check_val("both_run", gc_if.state, 1);
      check_val("both_player", gc_if.playernum, 1);

      // Reset while a jump pulse is high.
      seen = 0;
      btn[BJ] = 1'b1;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         tick();
         if (gc_if.jump === 1'b1) seen = 1;
      end
      check_val("jump_before_reset", seen, 1);
      #2 re_start = 1'b1;
      #1;
      check_val("midrst_state", gc_if.state, 0);
      check_val("midrst_outs", {gc_if.game_rst, gc_if.jump, gc_if.playernum, gc_if.showhighest,
                                gc_if.spd_level}, 0);
      btn = '0;
      model_reset();
      @(negedge clk);
      re_start = 1'b0;

      // Randomized play.
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
         gc_if.isover = ($urandom_range(0, 29) == 0);
         gc_if.scr = 16'($urandom_range(0, 80));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
